candy_arith_core: RTL and testbench
===================================

CANDY_ARITH_CORE -- requirements
Module: candy_arith_core

Interface
REQ-001 The block SHALL have no parameters; operand width SHALL be fixed at 24 bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high (1 = reset asserted).
REQ-004 valid_i  input  1  operands valid this cycle; capture request.
REQ-005 op1_i  input  24  first operand, unsigned.
REQ-006 op2_i  input  24  second operand, unsigned.
REQ-007 valid_o  output  1  sum_o/prod_o hold a newly computed result.
REQ-008 sum_o  output  25  registered op1 + op2; bit 24 is the carry-out.
REQ-009 prod_o  output  49  registered op1 * op2, zero-extended; bit 48 is always 0.

Function
REQ-010 The adder path SHALL compute a 25-bit unsigned sum, sum = op1_i + op2_i, with no overflow loss.
REQ-011 The adder path SHALL be a structural 24-bit carry-select adder.
- Operands split into fixed blocks of at most 6 bits.
- Each block above bit 0 computes both carry-in cases.
- Muxes select the block result on the incoming carry.
REQ-012 The multiplier path SHALL compute the 48-bit unsigned product op1_i * op2_i.
REQ-013 The multiplier SHALL be a Wallace tree.
- Uses 24 AND-generated partial-product rows.
- Reduces rows with 3:2 full-adder and 2:2 half-adder counters until two rows remain.
- A final 48-bit carry-propagate adder produces the product.
REQ-014 Behavioural '+' and '*' operators SHALL NOT be used to form the 24-bit sum or the product core; '+' is permitted only inside 1-bit counters and the final adder.
REQ-015 Both paths SHALL be purely combinational from op1_i/op2_i to the output registers.
REQ-016 Latency SHALL be exactly 1 cycle.
- When valid_i=1 at rising edge N, sum_o/prod_o hold the results of the operands sampled at edge N, from edge N onward.
- valid_o=1 in that same cycle.
REQ-017 When valid_i=0 at an edge, sum_o and prod_o SHALL hold their previous values and valid_o SHALL be 0.
REQ-018 Back-to-back valid_i=1 cycles SHALL produce one result per cycle with no bubbles.
REQ-019 Results SHALL be identical for all operand values, including 0 and 0xFFFFFF.
REQ-020 The low 24 bits SHALL remain two's-complement correct for the user.
- sum_o[23:0] is the correct result when op2_i is a negated subtrahend.
- prod_o[23:0] is the correct signed low product.

Reset
REQ-021 When rst=1 at a rising edge, the block SHALL clear valid_o, sum_o and prod_o to 0.
REQ-022 rst SHALL take priority over valid_i in the same cycle; operands presented during reset are discarded.
REQ-023 After rst deasserts, the first valid_i=1 edge SHALL produce a valid result with normal 1-cycle latency.
REQ-024 The block SHALL have no asynchronous reset behaviour; the reset value is undefined before the first clock edge with rst=1.

Verification
REQ-025 Carry-out case: op1=0xFFFFFF, op2=0x000001, valid_i=1.
- Next cycle: sum_o=0x1000000, prod_o=0x000000FFFFFF, valid_o=1.
REQ-026 Maximum operands: op1=0xFFFFFF, op2=0xFFFFFF.
- sum_o=0x1FFFFFE, prod_o=0x0FFFFFE000001.
REQ-027 Small values: op1=0x000003, op2=0x000005.
- sum_o=0x0000008, prod_o=15.
REQ-028 Power-of-two case: op1=0x800000, op2=0x000002.
- sum_o=0x0800002, prod_o=0x000001000000.
REQ-029 Hold: apply a result, then valid_i=0 with new operands.
- sum_o/prod_o unchanged, valid_o=0.
REQ-030 Reset mid-stream: rst=1 together with valid_i=1 and op1=op2=0x123456.
- Next cycle: all outputs 0.
- A random back-to-back stream of at least 10,000 vectors SHALL match a reference model.

Source files
------------

// File: rtl/candy_arith_core.sv
// candy_arith_core: registered 24-bit unsigned adder and multiplier.
//
// The adder is a structural carry-select adder built from 6-bit blocks. The
// multiplier ANDs out 24 partial-product rows, reduces them with a Wallace tree
// of full/half-adder counters down to two rows, and finishes with one 48-bit
// carry-propagate adder. Both results are captured one cycle after valid_i.
//
// Ports:
//   clk      single clock, rising edge
//   rst      synchronous active-high reset; clears all outputs
//   valid_i  operands valid this cycle
//   op1_i    first operand, 24-bit unsigned
//   op2_i    second operand, 24-bit unsigned
//   valid_o  sum_o/prod_o hold a newly computed result
//   sum_o    op1 + op2, bit 24 is the carry-out
//   prod_o   op1 * op2, zero-extended (bit 48 always 0)

module candy_arith_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [23:0] op1_i,
    input  logic [23:0] op2_i,
    output logic        valid_o,
    output logic [24:0] sum_o,
    output logic [48:0] prod_o
);

    localparam int unsigned Width  = 24;
    localparam int unsigned ProdW  = 48;
    localparam int unsigned BlkW   = 6;
    localparam int unsigned NumBlk = Width / BlkW;

    // Row count after one Wallace stage: each group of three rows becomes two,
    // leftover rows pass straight through.
    function automatic int next_rows(input int n);
        return 2 * (n / 3) + (n % 3);
    endfunction

    function automatic int rows_at(input int stage);
        int n;
        n = Width;
        for (int i = 0; i < stage; i++) begin
            n = next_rows(n);
        end
        return n;
    endfunction

    function automatic int num_stages();
        int n;
        int s;
        n = Width;
        s = 0;
        for (int i = 0; i < 16; i++) begin
            if (n > 2) begin
                n = next_rows(n);
                s++;
            end
        end
        return s;
    endfunction

    // Bits of a tree row that can ever be non-zero. Used at elaboration to pick
    // a full adder, half adder, wire or constant zero for each column position.
    function automatic logic [47:0] row_mask(input int stage, input int row);
        logic [23:0][47:0] cur;
        logic [23:0][47:0] nxt;
        int n;
        int q;
        int r;
        for (int i = 0; i < 24; i++) begin
            cur[i] = 48'hFF_FFFF << i;
        end
        n = Width;
        for (int st = 0; st < stage; st++) begin
            nxt = '0;
            q   = n / 3;
            r   = n % 3;
            for (int gi = 0; gi < q; gi++) begin
                nxt[2*gi]   = cur[3*gi] | cur[3*gi+1] | cur[3*gi+2];
                nxt[2*gi+1] = ((cur[3*gi] & cur[3*gi+1]) | (cur[3*gi] & cur[3*gi+2]) |
                               (cur[3*gi+1] & cur[3*gi+2])) << 1;
            end
            for (int k = 0; k < r; k++) begin
                nxt[2*q+k] = cur[3*q+k];
            end
            cur = nxt;
            n   = 2 * q + r;
        end
        return cur[row];
    endfunction

    localparam int NumStages = num_stages();

    // ------------------------------------------------------------------
    // Carry-select adder
    // ------------------------------------------------------------------
    logic [NumBlk:0]  blk_c;
    logic [Width-1:0] sum_lo;
    logic [Width:0]   sum_d;

    assign blk_c[0] = 1'b0;

    for (genvar k = 0; k < NumBlk; k++) begin : g_csa
        if (k == 0) begin : g_ripple
            logic [BlkW:0]   c;
            logic [BlkW-1:0] s;
            assign c[0] = blk_c[0];
            for (genvar i = 0; i < BlkW; i++) begin : g_fa
                assign {c[i+1], s[i]} = {1'b0, op1_i[k*BlkW+i]} + {1'b0, op2_i[k*BlkW+i]} +
                                        {1'b0, c[i]};
            end
            assign sum_lo[k*BlkW +: BlkW] = s;
            assign blk_c[k+1]             = c[BlkW];
        end else begin : g_select
            // Both carry-in cases are ready before the incoming carry arrives.
            logic [BlkW:0]   c0;
            logic [BlkW:0]   c1;
            logic [BlkW-1:0] s0;
            logic [BlkW-1:0] s1;
            assign c0[0] = 1'b0;
            assign c1[0] = 1'b1;
            for (genvar i = 0; i < BlkW; i++) begin : g_fa
                assign {c0[i+1], s0[i]} = {1'b0, op1_i[k*BlkW+i]} + {1'b0, op2_i[k*BlkW+i]} +
                                          {1'b0, c0[i]};
                assign {c1[i+1], s1[i]} = {1'b0, op1_i[k*BlkW+i]} + {1'b0, op2_i[k*BlkW+i]} +
                                          {1'b0, c1[i]};
            end
            assign sum_lo[k*BlkW +: BlkW] = blk_c[k] ? s1 : s0;
            assign blk_c[k+1]             = blk_c[k] ? c1[BlkW] : c0[BlkW];
        end
    end

    assign sum_d = {blk_c[NumBlk], sum_lo};

    // ------------------------------------------------------------------
    // Wallace-tree multiplier
    // ------------------------------------------------------------------
    logic [ProdW-1:0] tree [NumStages+1][Width];
    logic [ProdW-1:0] prod_d;

    for (genvar j = 0; j < Width; j++) begin : g_pp
        assign tree[0][j] = {{Width{1'b0}}, op1_i & {Width{op2_i[j]}}} << j;
    end

    for (genvar s = 0; s < NumStages; s++) begin : g_stage
        localparam int NIn  = rows_at(s);
        localparam int NGrp = NIn / 3;
        localparam int NRem = NIn % 3;
        localparam int NOut = 2 * NGrp + NRem;

        for (genvar g = 0; g < NGrp; g++) begin : g_grp
            localparam logic [ProdW-1:0] M0 = row_mask(s, 3 * g);
            localparam logic [ProdW-1:0] M1 = row_mask(s, 3 * g + 1);
            localparam logic [ProdW-1:0] M2 = row_mask(s, 3 * g + 2);

            // Carries out of bit 47 are dropped: the product always fits in 48 bits.
            logic [ProdW:0] cy;
            logic           unused_cy;
            assign cy[0]             = 1'b0;
            assign unused_cy         = cy[ProdW];
            assign tree[s+1][2*g+1]  = cy[ProdW-1:0];

            for (genvar b = 0; b < ProdW; b++) begin : g_bit
                localparam bit L0 = M0[b];
                localparam bit L1 = M1[b];
                localparam bit L2 = M2[b];

                if (L0 && L1 && L2) begin : g_fa
                    logic [1:0] cs;
                    assign cs = {1'b0, tree[s][3*g][b]} + {1'b0, tree[s][3*g+1][b]} +
                                {1'b0, tree[s][3*g+2][b]};
                    assign tree[s+1][2*g][b] = cs[0];
                    assign cy[b+1]           = cs[1];
                end else if (int'(L0) + int'(L1) + int'(L2) == 2) begin : g_ha
                    logic [1:0] cs;
                    assign cs = {1'b0, L0 ? tree[s][3*g][b] : tree[s][3*g+1][b]} +
                                {1'b0, L2 ? tree[s][3*g+2][b] : tree[s][3*g+1][b]};
                    assign tree[s+1][2*g][b] = cs[0];
                    assign cy[b+1]           = cs[1];
                end else if (L0 || L1 || L2) begin : g_wire
                    assign tree[s+1][2*g][b] = L0 ? tree[s][3*g][b] :
                                               (L1 ? tree[s][3*g+1][b] : tree[s][3*g+2][b]);
                    assign cy[b+1]           = 1'b0;
                end else begin : g_zero
                    assign tree[s+1][2*g][b] = 1'b0;
                    assign cy[b+1]           = 1'b0;
                end
            end
        end

        for (genvar k = 0; k < NRem; k++) begin : g_pass
            assign tree[s+1][2*NGrp+k] = tree[s][3*NGrp+k];
        end

        for (genvar r = NOut; r < Width; r++) begin : g_idle
            assign tree[s+1][r] = '0;
        end
    end

    // Final carry-propagate adder merges the last two rows.
    assign prod_d = tree[NumStages][0] + tree[NumStages][1];

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic             valid_q;
    logic [Width:0]   sum_q;
    logic [ProdW-1:0] prod_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
            prod_q  <= '0;
        end else begin
            valid_q <= valid_i;
            if (valid_i) begin
                sum_q  <= sum_d;
                prod_q <= prod_d;
            end
        end
    end

    assign valid_o = valid_q;
    assign sum_o   = sum_q;
    assign prod_o  = {1'b0, prod_q};

endmodule

// File: tb/tb_candy_arith_core.sv
// Scoreboard bench for candy_arith_core: every driven cycle pushes the expected
// outputs, which are popped and compared one edge later.

module tb_candy_arith_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [23:0] op1_i;
    logic [23:0] op2_i;
    logic        valid_o;
    logic [24:0] sum_o;
    logic [48:0] prod_o;

    always #5 clk = ~clk;

    candy_arith_core dut (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid_i),
        .op1_i   (op1_i),
        .op2_i   (op2_i),
        .valid_o (valid_o),
        .sum_o   (sum_o),
        .prod_o  (prod_o)
    );

    typedef struct packed {
        logic        v;
        logic [24:0] s;
        logic [48:0] p;
    } exp_t;

    exp_t sb [$];
    exp_t mdl;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle. With use_k set, the expected result comes from the given
    // constants instead of the reference model.
    task automatic step(input logic r, input logic v, input logic [23:0] a,
                        input logic [23:0] b, input bit use_k, input logic [24:0] ks,
                        input logic [48:0] kp, input string tag);
        exp_t e;
        rst     = r;
        valid_i = v;
        op1_i   = a;
        op2_i   = b;
        if (r) begin
            mdl = '0;
        end else begin
            mdl.v = v;
            if (v) begin
                if (use_k) begin
                    mdl.s = ks;
                    mdl.p = kp;
                end else begin
                    mdl.s = 25'(a) + 25'(b);
                    mdl.p = 49'(a) * 49'(b);
                end
            end
        end
        sb.push_back(mdl);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, "/valid"}, 64'(valid_o), 64'(e.v));
        check({tag, "/sum"},   64'(sum_o),   64'(e.s));
        check({tag, "/prod"},  64'(prod_o),  64'(e.p));
    endtask

    logic [23:0] da [7];
    logic [23:0] db [7];
    logic [24:0] ds [7];
    logic [48:0] dp [7];

    initial begin
        rst     = 1'b1;
        valid_i = 1'b0;
        op1_i   = '0;
        op2_i   = '0;
        mdl     = '0;

        da[0] = 24'hFF_FFFF; db[0] = 24'h00_0001; ds[0] = 25'h100_0000; dp[0] = 49'hFF_FFFF;
        da[1] = 24'hFF_FFFF; db[1] = 24'hFF_FFFF; ds[1] = 25'h1FF_FFFE;
        dp[1] = 49'hFFFF_FE00_0001;
        da[2] = 24'h00_0003; db[2] = 24'h00_0005; ds[2] = 25'h8;        dp[2] = 49'd15;
        da[3] = 24'h80_0000; db[3] = 24'h00_0002; ds[3] = 25'h80_0002;  dp[3] = 49'h100_0000;
        da[4] = 24'h00_0000; db[4] = 24'h00_0000; ds[4] = 25'h0;        dp[4] = 49'h0;
        // 100 + (-30): low 24 bits of sum are 70, low 24 bits of product are -3000.
        da[5] = 24'h00_0064; db[5] = 24'hFF_FFE2; ds[5] = 25'h100_0046; dp[5] = 49'h63FF_F448;
        da[6] = 24'hAB_CDEF; db[6] = 24'h00_0000; ds[6] = 25'hAB_CDEF;  dp[6] = 49'h0;

        step(1'b1, 1'b0, 24'h0, 24'h0, 1'b0, '0, '0, "reset");
        step(1'b1, 1'b1, 24'hAB_CDEF, 24'h12_3456, 1'b0, '0, '0, "reset_prio");

        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, da[i], db[i], 1'b1, ds[i], dp[i], $sformatf("dir%0d", i));
        end

        step(1'b0, 1'b1, 24'h00_0003, 24'h00_0005, 1'b1, 25'h8, 49'd15, "pre_hold");
        step(1'b0, 1'b0, 24'h11_1111, 24'h22_2222, 1'b1, '0, '0, "hold1");
        step(1'b0, 1'b0, 24'hFF_FFFF, 24'hFF_FFFF, 1'b1, '0, '0, "hold2");

        step(1'b1, 1'b1, 24'h12_3456, 24'h12_3456, 1'b0, '0, '0, "rst_mid");
        step(1'b0, 1'b0, 24'h12_3456, 24'h12_3456, 1'b0, '0, '0, "after_rst");
        step(1'b0, 1'b1, 24'h80_0000, 24'h00_0002, 1'b1, 25'h80_0002, 49'h100_0000,
             "first_valid");

        for (int i = 0; i < 10000; i++) begin
            logic [23:0] a;
            logic [23:0] b;
            logic        v;
            a = 24'($urandom);
            b = 24'($urandom);
            case ($urandom_range(0, 7))
                0: a = 24'h0;
                1: a = 24'hFF_FFFF;
                2: b = 24'hFF_FFFF;
                3: b = 24'h0;
                default: ;
            endcase
            v = ($urandom_range(0, 15) != 0);
            step(1'b0, v, a, b, 1'b0, '0, '0, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
